// File: rtl/lsu_stage_pkg.sv
// Shared definitions for the MEM-stage load/store unit: mem_op field layout,
// size encodings, FSM states and zero constants.
package lsu_stage_pkg;

  localparam int MEMOP_LOAD  = 4;
  localparam int MEMOP_STORE = 3;
  localparam int MEMOP_UNS   = 2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [63:0] ZERO_PC  = 64'h0;
  localparam logic [63:0] ZERO_NUM = 64'h0;
  localparam logic [4:0]  ZERO_REG = 5'h0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  // Byte-enable pattern for an access of the given size at offset 0.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_stage_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
// Request: a transfer happens on a cycle where mem_req_valid & mem_req_ready;
// the master holds all request fields stable until then. Response: a one-cycle
// mem_resp_valid pulse, at most one outstanding, always accepted.
interface lsu_stage_if #(
  parameter int DATA_W = 64,
  parameter int PC_W   = 64
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [PC_W-1:0]   mem_req_addr;
  logic              mem_req_wen;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [7:0]        mem_req_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_rdata;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Extracts the addressed lane from an 8-byte read word and sign/zero-extends it.
module lsu_load_align
  import lsu_stage_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [2:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] data
);
  logic [DATA_W-1:0] lane;

  assign lane = rdata >> {offset, 3'b000};

  always_comb begin
    data = lane;
    case (size)
      SZ_B:    data = {{(DATA_W-8){~is_unsigned & lane[7]}}, lane[7:0]};
      SZ_H:    data = {{(DATA_W-16){~is_unsigned & lane[15]}}, lane[15:0]};
      SZ_W:    data = {{(DATA_W-32){~is_unsigned & lane[31]}}, lane[31:0]};
      default: data = lane;
    endcase
  end
endmodule

// File: rtl/lsu_stage.sv
// MEM-stage load/store unit: takes one instruction from EX, performs the memory
// access if any, and presents the writeback result to the MEM/WB register.
module lsu_stage
  import lsu_stage_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int PC_W    = 64,
  parameter int RADDR_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               in_w_ena,
  input  logic [RADDR_W-1:0] in_w_addr,
  input  logic [DATA_W-1:0]  in_alu_res,
  input  logic [DATA_W-1:0]  in_store_data,
  input  logic [4:0]         in_mem_op,
  lsu_stage_if.master        mem,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic               out_w_ena,
  output logic [RADDR_W-1:0] out_w_addr,
  output logic [DATA_W-1:0]  out_w_data,
  output state_t             dbg_state
);
  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q;
  logic               w_ena_q;
  logic [RADDR_W-1:0] w_addr_q;
  logic [DATA_W-1:0]  alu_q;
  logic [DATA_W-1:0]  sdata_q;
  logic [DATA_W-1:0]  res_q;
  logic [4:0]         op_q;
  logic [DATA_W-1:0]  load_data;
  logic               accept;
  logic               in_is_mem;
  logic               req_active;

  assign in_is_mem  = in_mem_op[MEMOP_LOAD] | in_mem_op[MEMOP_STORE];
  assign in_ready   = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept     = in_valid & in_ready & ~flush;
  assign req_active = (state_q == S_REQ);

  // Valids are gated by flush combinationally so a redirect kills them at once.
  assign out_valid         = (state_q == S_DONE) & ~flush;
  assign mem.mem_req_valid = req_active & ~flush;
  assign mem.mem_req_addr  = req_active ? {alu_q[PC_W-1:3], 3'b000} : PC_W'(ZERO_PC);
  assign mem.mem_req_wen   = req_active & op_q[MEMOP_STORE];
  assign mem.mem_req_wdata = req_active ? (sdata_q << {alu_q[2:0], 3'b000}) : DATA_W'(ZERO_NUM);
  assign mem.mem_req_wmask = req_active ? (size_mask(op_q[1:0]) << alu_q[2:0]) : 8'h00;

  assign out_pc     = pc_q;
  assign out_w_ena  = w_ena_q;
  assign out_w_addr = w_addr_q;
  assign out_w_data = res_q;
  assign dbg_state  = state_q;

  lsu_load_align #(.DATA_W(DATA_W)) u_load_align (
    .rdata       (mem.mem_resp_rdata),
    .offset      (alu_q[2:0]),
    .size        (op_q[1:0]),
    .is_unsigned (op_q[MEMOP_UNS]),
    .data        (load_data)
  );

  always_comb begin
    state_d = state_q;
    if (flush) begin
      case (state_q)
        S_REQ:   state_d = (mem.mem_req_valid && mem.mem_req_ready) ? S_DRAIN : S_IDLE;
        S_WAIT:  state_d = S_DRAIN;
        S_DRAIN: state_d = mem.mem_resp_valid ? S_IDLE : S_DRAIN;
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE:  if (accept) state_d = in_is_mem ? S_REQ : S_DONE;
        S_REQ:   if (mem.mem_req_ready) state_d = S_WAIT;
        S_WAIT:  if (mem.mem_resp_valid) state_d = S_DONE;
        S_DONE:  if (out_ready) state_d = accept ? (in_is_mem ? S_REQ : S_DONE) : S_IDLE;
        S_DRAIN: if (mem.mem_resp_valid) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= PC_W'(ZERO_PC);
      w_ena_q  <= 1'b0;
      w_addr_q <= RADDR_W'(ZERO_REG);
      alu_q    <= DATA_W'(ZERO_NUM);
      sdata_q  <= DATA_W'(ZERO_NUM);
      res_q    <= DATA_W'(ZERO_NUM);
      op_q     <= 5'b00000;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pc_q     <= in_pc;
        w_ena_q  <= in_w_ena;
        w_addr_q <= in_w_addr;
        alu_q    <= in_alu_res;
        sdata_q  <= in_store_data;
        op_q     <= in_mem_op;
        res_q    <= in_is_mem ? DATA_W'(ZERO_NUM) : in_alu_res;
      end else if ((state_q == S_WAIT) && mem.mem_resp_valid && !flush) begin
        res_q <= op_q[MEMOP_LOAD] ? load_data : DATA_W'(ZERO_NUM);
      end
    end
  end
endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: directed scenarios plus a randomized mix
// compared against a byte-level reference model of loads and stores.
module tb_lsu_stage;
  import lsu_stage_pkg::*;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic        in_w_ena;
  logic [4:0]  in_w_addr;
  logic [63:0] in_alu_res;
  logic [63:0] in_store_data;
  logic [4:0]  in_mem_op;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic        out_w_ena;
  logic [4:0]  out_w_addr;
  logic [63:0] out_w_data;
  state_t      dbg_state;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  lsu_stage_if #(.DATA_W(64), .PC_W(64)) mem();

  lsu_stage #(.DATA_W(64), .PC_W(64), .RADDR_W(5)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_w_ena(in_w_ena),
    .in_w_addr(in_w_addr), .in_alu_res(in_alu_res), .in_store_data(in_store_data),
    .in_mem_op(in_mem_op), .mem(mem),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_w_ena(out_w_ena),
    .out_w_addr(out_w_addr), .out_w_data(out_w_data), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] ref_mask(input logic [63:0] addr, input logic [4:0] op);
    logic [7:0] m;
    int n;
    m = 8'h00;
    n = 1 << op[1:0];
    for (int k = 0; k < n; k++)
      if (int'(addr[2:0]) + k < 8) m[int'(addr[2:0]) + k] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] sdata, input logic [63:0] addr);
    logic [63:0] v;
    int off;
    v = '0;
    off = int'(addr[2:0]);
    for (int j = off; j < 8; j++) v[8*j +: 8] = sdata[8*(j-off) +: 8];
    return v;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] word, input logic [63:0] addr,
                                           input logic [4:0] op);
    logic [63:0] v;
    int n;
    int off;
    v = '0;
    n = 1 << op[1:0];
    off = int'(addr[2:0]);
    for (int k = 0; k < n; k++)
      if (off + k < 8) v[8*k +: 8] = word[8*(off+k) +: 8];
    if (!op[2] && n < 8 && v[8*n-1])
      for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] ref_result(input logic [63:0] alu, input logic [4:0] op,
                                             input logic [63:0] rdata);
    if (op[4]) return ref_load(rdata, alu, op);
    if (op[3]) return 64'h0;
    return alu;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_in(input logic [63:0] pc, input logic [63:0] alu, input logic [63:0] sdata,
                          input logic [4:0] op, input logic [4:0] waddr, input logic wena);
    in_valid = 1'b1; in_pc = pc; in_alu_res = alu; in_store_data = sdata;
    in_mem_op = op; in_w_addr = waddr; in_w_ena = wena;
  endtask

  // Runs one memory op from IDLE to IDLE and reports what was observed.
  task automatic run_mem_op(input logic [63:0] pc, input logic [63:0] alu, input logic [63:0] sdata,
                            input logic [4:0] op, input logic [4:0] waddr, input logic [63:0] rdata,
                            input int ready_delay, input int resp_delay, input int out_delay,
                            output logic [63:0] o_addr, output logic [63:0] o_wdata,
                            output logic [7:0] o_wmask, output logic o_wen,
                            output logic [63:0] o_data, output logic o_valid,
                            output logic o_stable, output logic o_quiet, output logic o_timeout);
    int n;
    o_stable = 1'b1; o_quiet = 1'b1; o_timeout = 1'b0; o_valid = 1'b0;
    out_ready = 1'b1;
    drive_in(pc, alu, sdata, op, waddr, 1'b0);
    tick();
    in_valid = 1'b0;
    mem.mem_req_ready = 1'b0;
    #1;
    n = 0;
    while (!mem.mem_req_valid && n < 10) begin
      tick(); n++;
    end
    if (n == 10) o_timeout = 1'b1;
    o_addr = mem.mem_req_addr; o_wdata = mem.mem_req_wdata;
    o_wmask = mem.mem_req_wmask; o_wen = mem.mem_req_wen;
    if (in_ready || out_valid) o_stable = 1'b0;
    repeat (ready_delay) begin
      tick(); #1;
      if (!mem.mem_req_valid || mem.mem_req_addr !== o_addr || mem.mem_req_wdata !== o_wdata ||
          mem.mem_req_wmask !== o_wmask || mem.mem_req_wen !== o_wen || in_ready || out_valid)
        o_stable = 1'b0;
    end
    mem.mem_req_ready = 1'b1;
    tick();
    mem.mem_req_ready = 1'b0;
    repeat (resp_delay) begin
      #1;
      if (out_valid || mem.mem_req_valid) o_quiet = 1'b0;
      tick();
    end
    mem.mem_resp_valid = 1'b1; mem.mem_resp_rdata = rdata;
    #1;
    if (out_valid) o_quiet = 1'b0;
    tick();
    mem.mem_resp_valid = 1'b0; mem.mem_resp_rdata = {$urandom, $urandom};
    #1;
    o_valid = out_valid; o_data = out_w_data;
    out_ready = 1'b0;
    #1;
    if (in_ready) o_stable = 1'b0;
    repeat (out_delay) begin
      tick(); #1;
      if (!out_valid || out_w_data !== o_data || out_pc !== pc || in_ready) o_stable = 1'b0;
    end
    out_ready = 1'b1;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0 || mem.mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_valids got=%b%b exp=00", out_valid, mem.mem_req_valid); end
    checks++; if (out_w_data !== 64'h0 || out_pc !== 64'h0 || out_w_addr !== 5'h0 || out_w_ena !== 1'b0) begin failures++; $display("FAIL reset_out got=%h/%h exp=0", out_w_data, out_pc); end
    checks++; if (mem.mem_req_wmask !== 8'h00 || mem.mem_req_addr !== 64'h0 || mem.mem_req_wdata !== 64'h0 || mem.mem_req_wen !== 1'b0) begin failures++; $display("FAIL reset_req got=%h/%h exp=0", mem.mem_req_wmask, mem.mem_req_addr); end
  endtask

  task automatic test_alu_passthrough();
    out_ready = 1'b1;
    drive_in(64'h8000_0000, 64'h1234, 64'h0, 5'b00000, 5'd5, 1'b1);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL alu_in_ready got=%b exp=1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL alu_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_w_data !== 64'h1234) begin failures++; $display("FAIL alu_data got=%h exp=1234", out_w_data); end
    checks++; if (out_w_addr !== 5'd5 || out_w_ena !== 1'b1 || out_pc !== 64'h8000_0000) begin failures++; $display("FAIL alu_fields got=%0d/%b/%h exp=5/1/80000000", out_w_addr, out_w_ena, out_pc); end
    tick();
    checks++; if (out_valid !== 1'b0 || dbg_state !== S_IDLE) begin failures++; $display("FAIL alu_retire got=%b/%0d exp=0/%0d", out_valid, dbg_state, S_IDLE); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] alu_v;
    logic [63:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_v = {$urandom, $urandom};
      exp_q.push_back(alu_v);
      drive_in(64'h1000 + 64'(4*i), alu_v, 64'h0, 5'b00000, 5'(i + 1), 1'b1);
      tick();
      exp = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || out_w_data !== exp) begin failures++; $display("FAIL b2b_%0d got=%b/%h exp=1/%h", i, out_valid, out_w_data, exp); end
      checks++; if (out_pc !== 64'h1000 + 64'(4*i)) begin failures++; $display("FAIL b2b_pc_%0d got=%h exp=%h", i, out_pc, 64'h1000 + 64'(4*i)); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_load_byte();
    logic [63:0] a, wd, d;
    logic [7:0] m;
    logic we, v, st, q, to;
    run_mem_op(64'h44, 64'h8000_0003, 64'h0, 5'b10000, 5'd7, 64'h0000_0000_80FF_0000,
               0, 0, 0, a, wd, m, we, d, v, st, q, to);
    checks++; if (to || a !== 64'h8000_0000) begin failures++; $display("FAIL lb_addr got=%h exp=80000000", a); end
    checks++; if (we !== 1'b0 || m !== 8'h08) begin failures++; $display("FAIL lb_req got=%b/%h exp=0/08", we, m); end
    checks++; if (!v || d !== 64'hFFFF_FFFF_FFFF_FF80) begin failures++; $display("FAIL lb_data got=%b/%h exp=1/ffffffffffffff80", v, d); end
    run_mem_op(64'h48, 64'h8000_0003, 64'h0, 5'b10100, 5'd7, 64'h0000_0000_80FF_0000,
               0, 0, 0, a, wd, m, we, d, v, st, q, to);
    checks++; if (to || !v || d !== 64'h80) begin failures++; $display("FAIL lbu_data got=%b/%h exp=1/80", v, d); end
  endtask

  task automatic test_store_word();
    logic [63:0] a, wd, d;
    logic [7:0] m;
    logic we, v, st, q, to;
    run_mem_op(64'h50, 64'h8000_0004, 64'hDEAD_BEEF, 5'b01010, 5'd0, 64'h1111_2222_3333_4444,
               0, 2, 0, a, wd, m, we, d, v, st, q, to);
    checks++; if (to || m !== 8'hF0 || we !== 1'b1) begin failures++; $display("FAIL sw_mask got=%h/%b exp=f0/1", m, we); end
    checks++; if (wd !== 64'hDEAD_BEEF_0000_0000 || a !== 64'h8000_0000) begin failures++; $display("FAIL sw_wdata got=%h/%h exp=deadbeef00000000/80000000", wd, a); end
    checks++; if (q !== 1'b1) begin failures++; $display("FAIL sw_early_out got=%b exp=1", q); end
    checks++; if (v !== 1'b1 || d !== 64'h0) begin failures++; $display("FAIL sw_done got=%b/%h exp=1/0", v, d); end
  endtask

  task automatic test_backpressure();
    logic [63:0] a, wd, d;
    logic [7:0] m;
    logic we, v, st, q, to;
    run_mem_op(64'h60, 64'h2006, 64'h0, 5'b10001, 5'd9, 64'h7FFF_0000_0000_0000,
               3, 1, 2, a, wd, m, we, d, v, st, q, to);
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL bp_stable got=%b exp=1", st); end
    checks++; if (to || !v || d !== 64'h7FFF) begin failures++; $display("FAIL bp_data got=%b/%h exp=1/7fff", v, d); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL bp_idle got=%0d exp=%0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_flush();
    logic [63:0] a, wd, d;
    logic [7:0] m;
    logic we, v, st, q, to;
    // Flush while WAIT: response two cycles later is swallowed.
    out_ready = 1'b1;
    drive_in(64'h70, 64'h8000_0010, 64'h0, 5'b10011, 5'd3, 1'b1);
    tick();
    in_valid = 1'b0; mem.mem_req_ready = 1'b1;
    tick();
    mem.mem_req_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checks++; if (dbg_state !== S_DRAIN || out_valid !== 1'b0) begin failures++; $display("FAIL fw_drain got=%0d/%b exp=%0d/0", dbg_state, out_valid, S_DRAIN); end
    tick();
    mem.mem_resp_valid = 1'b1; mem.mem_resp_rdata = 64'hABCD;
    tick();
    mem.mem_resp_valid = 1'b0;
    #1;
    checks++; if (dbg_state !== S_IDLE || out_valid !== 1'b0) begin failures++; $display("FAIL fw_idle got=%0d/%b exp=%0d/0", dbg_state, out_valid, S_IDLE); end
    // Stray response in IDLE is ignored.
    mem.mem_resp_valid = 1'b1;
    tick();
    mem.mem_resp_valid = 1'b0;
    #1;
    checks++; if (dbg_state !== S_IDLE || out_valid !== 1'b0) begin failures++; $display("FAIL stray_resp got=%0d/%b exp=%0d/0", dbg_state, out_valid, S_IDLE); end
    run_mem_op(64'h74, 64'h8000_0010, 64'h0, 5'b10011, 5'd3, 64'h0123_4567_89AB_CDEF,
               0, 1, 0, a, wd, m, we, d, v, st, q, to);
    checks++; if (to || !v || d !== 64'h0123_4567_89AB_CDEF) begin failures++; $display("FAIL fw_next got=%b/%h exp=1/0123456789abcdef", v, d); end
    // Flush in REQ: request withdrawn at once, back to IDLE.
    drive_in(64'h78, 64'h8000_0020, 64'h0, 5'b10010, 5'd4, 1'b1);
    tick();
    in_valid = 1'b0; flush = 1'b1; mem.mem_req_ready = 1'b1;
    #1;
    checks++; if (mem.mem_req_valid !== 1'b0) begin failures++; $display("FAIL fr_gate got=%b exp=0", mem.mem_req_valid); end
    tick();
    flush = 1'b0; mem.mem_req_ready = 1'b0;
    #1;
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL fr_idle got=%0d exp=%0d", dbg_state, S_IDLE); end
    // Flush in DONE with a pending instruction: no accept.
    drive_in(64'h7C, 64'h55, 64'h0, 5'b00000, 5'd6, 1'b1);
    tick();
    drive_in(64'h80, 64'h66, 64'h0, 5'b00000, 5'd6, 1'b1);
    flush = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fd_gate got=%b exp=0", out_valid); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (dbg_state !== S_IDLE || out_valid !== 1'b0) begin failures++; $display("FAIL fd_noaccept got=%0d/%b exp=%0d/0", dbg_state, out_valid, S_IDLE); end
  endtask

  task automatic test_reset_mid_req();
    drive_in(64'h90, 64'h8000_0001, 64'hFFFF, 5'b01001, 5'd2, 1'b0);
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (mem.mem_req_valid !== 1'b1) begin failures++; $display("FAIL rr_pre got=%b exp=1", mem.mem_req_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++; if (dbg_state !== S_IDLE || in_ready !== 1'b1) begin failures++; $display("FAIL rr_state got=%0d/%b exp=%0d/1", dbg_state, in_ready, S_IDLE); end
    checks++; if (mem.mem_req_valid !== 1'b0 || mem.mem_req_wmask !== 8'h00 || mem.mem_req_wdata !== 64'h0 || mem.mem_req_addr !== 64'h0 || mem.mem_req_wen !== 1'b0) begin failures++; $display("FAIL rr_req got=%b/%h/%h exp=0", mem.mem_req_valid, mem.mem_req_wmask, mem.mem_req_addr); end
    checks++; if (out_valid !== 1'b0 || out_pc !== 64'h0 || out_w_data !== 64'h0 || out_w_addr !== 5'h0) begin failures++; $display("FAIL rr_out got=%b/%h/%h exp=0", out_valid, out_pc, out_w_data); end
  endtask

  task automatic test_random();
    logic [63:0] a, wd, d, alu_v, sd, rd, exp;
    logic [7:0] m;
    logic we, v, st, q, to;
    logic [4:0] op;
    int kind;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      alu_v = {$urandom, $urandom};
      sd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      if (kind == 0) op = 5'b00000;
      else if (kind == 1) op = {2'b10, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
      else op = {3'b010, 2'($urandom_range(0, 3))};
      exp_q.push_back(ref_result(alu_v, op, rd));
      if (kind == 0) begin
        out_ready = 1'b1;
        drive_in(64'(i), alu_v, sd, op, 5'(i), 1'b1);
        tick();
        in_valid = 1'b0;
        #1;
        exp = exp_q.pop_front();
        checks++; if (out_valid !== 1'b1 || out_w_data !== exp) begin failures++; $display("FAIL rnd_alu_%0d got=%b/%h exp=1/%h", i, out_valid, out_w_data, exp); end
        tick();
      end else begin
        run_mem_op(64'(i), alu_v, sd, op, 5'(i), rd, $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom_range(0, 1), a, wd, m, we, d, v, st, q, to);
        exp = exp_q.pop_front();
        checks++; if (to || a !== {alu_v[63:3], 3'b000} || m !== ref_mask(alu_v, op) || we !== op[3]) begin failures++; $display("FAIL rnd_req_%0d got=%h/%h/%b exp=%h/%h/%b", i, a, m, we, {alu_v[63:3], 3'b000}, ref_mask(alu_v, op), op[3]); end
        if (op[3]) begin
          checks++; if (wd !== ref_wdata(sd, alu_v)) begin failures++; $display("FAIL rnd_wdata_%0d got=%h exp=%h", i, wd, ref_wdata(sd, alu_v)); end
        end
        checks++; if (!v || d !== exp || !st || !q) begin failures++; $display("FAIL rnd_mem_%0d op=%b got=%b/%h st=%b q=%b exp=1/%h", i, op, v, d, st, q, exp); end
      end
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_w_ena = 1'b0; in_w_addr = '0;
    in_alu_res = '0; in_store_data = '0; in_mem_op = '0; out_ready = 1'b1;
    mem.mem_req_ready = 1'b0; mem.mem_resp_valid = 1'b0; mem.mem_resp_rdata = '0;
    test_reset();
    test_alu_passthrough();
    test_back_to_back();
    test_load_byte();
    test_store_word();
    test_backpressure();
    test_flush();
    test_reset_mid_req();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- MEM-stage producer sitting between the EX/MEM boundary and the MEM/WB pipeline register.
- Accepts one instruction at a time from EX over a valid/ready handshake.
- For loads and stores, performs the data-memory access over a request/response bus; loads are aligned and sign- or zero-extended.
- Presents the writeback triple plus PC to the MEM/WB register, driving out_valid and honouring out_ready.

Parameters:
- DATA_W, 64, data path and register width
- PC_W, 64, PC and address width
- RADDR_W, 5, register-file address width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- flush  in  1  kill the held instruction (pipeline redirect)
- in_valid  in  1  EX presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_pc  in  PC_W  instruction PC
- in_w_ena  in  1  register write enable
- in_w_addr  in  RADDR_W  destination register
- in_alu_res  in  DATA_W  ALU result / effective address
- in_store_data  in  DATA_W  rs2 value for stores
- in_mem_op  in  5  [4] load, [3] store, [2] unsigned, [1:0] size (0=B, 1=H, 2=W, 3=D); 00000 = no access
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  PC_W  address, 8-byte aligned (low 3 bits zeroed)
- mem_req_wen  out  1  1 = store
- mem_req_wdata  out  DATA_W  store data, lane-shifted
- mem_req_wmask  out  8  byte enables
- mem_resp_valid  in  1  response / write acknowledge
- mem_resp_rdata  in  DATA_W  read data, 8-byte word
- out_valid  out  1  result valid to MEM/WB
- out_ready  in  1  MEM/WB accepts
- out_pc  out  PC_W  PC
- out_w_ena  out  1  register write enable
- out_w_addr  out  RADDR_W  destination register
- out_w_data  out  DATA_W  writeback data

Behaviour:
- States:
  - IDLE: empty.
  - REQ: mem_req_valid high.
  - WAIT: request accepted, awaiting response.
  - DONE: out_valid high.
  - DRAIN: flushed while a response is still owed.
- Reset:
  - state = IDLE.
  - All out_* signals, mem_req_* signals and the held registers are 0.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is forced to 0 in REQ, WAIT and DRAIN.
- Accept rule: in_valid & in_ready & ~flush. On accept, the stage latches pc, w_ena, w_addr, alu_res, store_data and mem_op.
  - mem_op[4:3] == 00: next state DONE, out_w_data = alu_res. Latency is 1 cycle (accept at N, out_valid at N+1).
  - Load or store: next state REQ.
- REQ:
  - mem_req_valid = 1, mem_req_addr = {alu_res[PC_W-1:3], 000}.
  - wmask = size mask (0x01, 0x03, 0x0F, 0xFF) << alu_res[2:0], truncated to 8 bits.
  - wdata = store_data << (8*alu_res[2:0]).
  - req_valid & req_ready -> WAIT. Request fields are held stable until the handshake.
- WAIT: on mem_resp_valid -> DONE.
  - Load: byte lane = rdata >> (8*alu_res[2:0]), truncated to size, then sign-extended (unsigned=0) or zero-extended.
  - Store: out_w_data = 0 and out_w_ena passes through (EX drives 0).
- DONE: out_valid = 1.
  - out_ready with a new accept -> reload.
  - out_ready without accept -> IDLE.
  - out_* are held stable while out_ready = 0.
- Back-to-back: a DONE -> DONE reload with non-memory ops sustains 1 instruction per cycle.
- Flush (priority over all other transitions):
  - IDLE, DONE or REQ -> IDLE. out_valid and mem_req_valid drop the same cycle (combinational gating). No accept occurs that cycle.
  - A REQ whose handshake completes in the flush cycle counts as issued -> DRAIN.
  - WAIT -> DRAIN.
  - DRAIN: discards the next mem_resp_valid, then -> IDLE. Flush while already in DRAIN has no effect.
- Response: at most one outstanding. mem_resp_valid outside WAIT/DRAIN is ignored.
- Misaligned accesses are unsupported: mask bits shifted past byte 7 are dropped; no trap is raised.
- A synchronous reset in any state, including mid-request, returns to the reset values. The memory side is reset by the same reset.

Decomposition:
- Shared defines file:
  - mem_op field positions and size encodings (MEMOP_LOAD, MEMOP_STORE, MEMOP_UNS, SZ_B/H/W/D).
  - FSM state encodings.
  - Zero constants, reusing the existing ZERO_PC, ZERO_REG and ZERO_NUM.
- One natural sub-module: lsu_load_align (combinational: rdata, offset, size, unsigned -> extended data). Instantiated once in the WAIT path.

Test Plan:
- ALU passthrough: accept pc=0x80000000, mem_op=0, alu_res=0x1234, w_addr=5, out_ready=1 -> out_valid next cycle, out_w_data=0x1234, out_w_addr=5. Four back-to-back ops give 4 outputs in 4 consecutive cycles.
- Signed byte load: alu_res=0x80000003, mem_op=LB, rdata=0x00000000_80FF0000 -> req_addr=0x80000000, out_w_data=0xFFFFFFFF_FFFFFF80. The same access with LBU gives 0x80.
- Store word: alu_res=0x80000004, store_data=0xDEADBEEF, mem_op=SW -> wmask=0xF0, wdata=0xDEADBEEF_00000000, wen=1. out_valid comes only after mem_resp_valid.
- Backpressure: hold mem_req_ready=0 for 3 cycles, then out_ready=0 for 2 cycles -> req fields and out fields stay stable, and in_ready stays 0 until out_ready rises.
- Flush in WAIT: load issued, flush asserted, response 2 cycles later -> no out_valid; state returns to IDLE; the next load completes normally.
- Reset mid-REQ: reset asserted while mem_req_valid=1 -> the next cycle all outputs are 0, state is IDLE and in_ready=1.
